// File: rtl/paridade_quadro.sv
// paridade_quadro: streaming frame parity generator/checker.
// Accumulates XOR parity over a multi-word frame (valid/ready in) and returns
// one registered result per frame (valid/ready out). Mode is latched on the
// first beat of each frame; the received parity bit is sampled with the last beat.
// Optional build macro PER_WORD_PAR_EN adds a one-cycle per-word parity
// strobe (word_par / word_par_valid), matching the legacy single-word generator.
module paridade_quadro #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_WORDS = 16,
  parameter int unsigned ODD       = 1,
  localparam int unsigned CW       = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_err,
  output logic             out_ovf,
  output logic [CW-1:0]    out_count
`ifdef PER_WORD_PAR_EN
  ,
  output logic             word_par,
  output logic             word_par_valid
`endif
);

  localparam logic ODD_B = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic            mode_q,      mode_d;
  logic            acc_q,       acc_d;
  logic [CW-1:0]   count_q,     count_d;
  logic            ovf_q,       ovf_d;
  logic            in_ready_q,  in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            out_par_q,   out_par_d;
  logic            out_err_q,   out_err_d;
  logic            out_ovf_q,   out_ovf_d;
  logic [CW-1:0]   out_count_q, out_count_d;

  logic            beat;
  logic            word_p;
  logic            sat;
  logic            f_mode;
  logic            f_acc;
  logic [CW-1:0]   f_count;
  logic            f_ovf;

  // Running frame values including the current beat, then next-state decode.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_par_d   = out_par_q;
    out_err_d   = out_err_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;

    beat    = in_valid && in_ready_q;
    word_p  = ^in_data;
    sat     = (state_q == ACCUM) && (count_q == CW'(MAX_WORDS));
    f_mode  = (state_q == IDLE) ? mode : mode_q;
    f_acc   = ((state_q == IDLE) ? 1'b0 : acc_q) ^ word_p;
    f_count = (state_q == IDLE) ? CW'(1) : (sat ? count_q : count_q + CW'(1));
    f_ovf   = (state_q == IDLE) ? 1'b0 : (ovf_q | sat);

    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          mode_d  = f_mode;
          acc_d   = f_acc;
          count_d = f_count;
          ovf_d   = f_ovf;
          if (in_last) begin
            state_d     = RESULT;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_par_d   = f_acc ^ ODD_B;
            out_err_d   = f_mode && ((f_acc ^ in_par) != ODD_B);
            out_ovf_d   = f_ovf;
            out_count_d = f_count;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_par_d   = 1'b0;
          out_err_d   = 1'b0;
          out_ovf_d   = 1'b0;
          out_count_d = '0;
          mode_d      = 1'b0;
          acc_d       = 1'b0;
          count_d     = '0;
          ovf_d       = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      acc_q       <= 1'b0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_par_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_par_q   <= out_par_d;
      out_err_q   <= out_err_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_par   = out_par_q;
  assign out_err   = out_err_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;

`ifdef PER_WORD_PAR_EN
  logic word_par_q,       word_par_d;
  logic word_par_valid_q, word_par_valid_d;

  // Per-word parity strobe, one cycle after each accepted beat.
  always_comb begin
    word_par_valid_d = beat;
    word_par_d       = beat ? (word_p ^ ODD_B) : 1'b0;
  end

  // Per-word strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_par_q       <= 1'b0;
      word_par_valid_q <= 1'b0;
    end else begin
      word_par_q       <= word_par_d;
      word_par_valid_q <= word_par_valid_d;
    end
  end

  assign word_par       = word_par_q;
  assign word_par_valid = word_par_valid_q;
`endif

endmodule
